// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: write-pointer sync, read pointers, EMPTY, FWFT output stage.
// Optional RD_LEVEL_EN adds RD_LEVEL and ALMOST_EMPTY outputs.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_WIDTH  = 4,
    parameter int AE_THRESH  = 2
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    input  logic [PTR_WIDTH-1:0]  g_wptr,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic [PTR_WIDTH-1:0]  b_rptr,
    output logic [PTR_WIDTH-1:0]  g_rptr,
    output logic                  R_INC,
    output logic                  EMPTY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY
`ifdef RD_LEVEL_EN
    ,
    output logic [PTR_WIDTH-1:0]  RD_LEVEL,
    output logic                  ALMOST_EMPTY
`endif
);

    logic [PTR_WIDTH-1:0] sync1;
    logic [PTR_WIDTH-1:0] sync2;
    logic [PTR_WIDTH-1:0] b_rptr_next;
    logic [PTR_WIDTH-1:0] g_rptr_next;

    // Pop only when memory has data and the output slot is free or being drained.
    assign R_INC = ~EMPTY & (~OUT_VALID | OUT_READY);

    assign b_rptr_next = b_rptr + {{(PTR_WIDTH-1){1'b0}}, R_INC};
    assign g_rptr_next = b_rptr_next ^ (b_rptr_next >> 1);

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            sync1  <= '0;
            sync2  <= '0;
            b_rptr <= '0;
            g_rptr <= '0;
            EMPTY  <= 1'b1;
        end else begin
            sync1  <= g_wptr;
            sync2  <= sync1;
            b_rptr <= b_rptr_next;
            g_rptr <= g_rptr_next;
            EMPTY  <= (g_rptr_next == sync2);
        end
    end

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            OUT_DATA  <= '0;
            OUT_VALID <= 1'b0;
        end else if (R_INC) begin
            OUT_DATA  <= MEM_RDATA;
            OUT_VALID <= 1'b1;
        end else if (OUT_VALID & OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef RD_LEVEL_EN
    localparam logic [PTR_WIDTH-1:0] AE_T = PTR_WIDTH'(AE_THRESH);

    logic [PTR_WIDTH-1:0] b_wptr_sync;
    logic [PTR_WIDTH-1:0] level_next;

    always_comb begin
        b_wptr_sync[PTR_WIDTH-1] = sync2[PTR_WIDTH-1];
        for (int i = PTR_WIDTH-2; i >= 0; i--) begin
            b_wptr_sync[i] = b_wptr_sync[i+1] ^ sync2[i];
        end
    end

    // Level counts words still in memory; the word in OUT_DATA is excluded.
    assign level_next = b_wptr_sync - b_rptr_next;

    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            RD_LEVEL     <= '0;
            ALMOST_EMPTY <= 1'b1;
        end else begin
            RD_LEVEL     <= level_next;
            ALMOST_EMPTY <= (level_next <= AE_T);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed testbench for fifo_rd_ctrl with a behavioural async-read memory.
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] g_wptr;
    logic [7:0] mem_rdata;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       r_inc;
    logic       empty;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef RD_LEVEL_EN
    logic [3:0] rd_level;
    logic       almost_empty;
`endif

    logic [7:0] mem [0:7];
    int checks = 0;
    int errors = 0;

    assign mem_rdata = mem[b_rptr[2:0]];

    fifo_rd_ctrl #(
        .DATA_WIDTH(8), .FIFO_DEPTH(8), .PTR_WIDTH(4), .AE_THRESH(2)
    ) dut (
        .R_CLK(clk),
        .R_RST(rst_n),
        .g_wptr(g_wptr),
        .MEM_RDATA(mem_rdata),
        .b_rptr(b_rptr),
        .g_rptr(g_rptr),
        .R_INC(r_inc),
        .EMPTY(empty),
        .OUT_DATA(out_data),
        .OUT_VALID(out_valid),
        .OUT_READY(out_ready)
`ifdef RD_LEVEL_EN
        ,
        .RD_LEVEL(rd_level),
        .ALMOST_EMPTY(almost_empty)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        g_wptr = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        g_wptr = 4'b0110;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (empty !== 1'b1 || out_valid !== 1'b0 || b_rptr !== 4'd0 ||
                g_rptr !== 4'd0 || r_inc !== 1'b0 || out_data !== 8'h00) begin
                errors++;
                $display("FAIL reset cyc%0d: empty=%b valid=%b b=%h g=%h inc=%b data=%h, need 1 0 0 0 0 00",
                         i, empty, out_valid, b_rptr, g_rptr, r_inc, out_data);
            end
        end
`ifdef RD_LEVEL_EN
        checks++;
        if (rd_level !== 4'd0 || almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_level: level=%0d ae=%b, need 0 1", rd_level, almost_empty);
        end
`endif
        g_wptr = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        mem[0] = 8'hA5;
        out_ready = 1'b1;
        g_wptr = 4'b0001;
        tick();
        tick();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL single_e2: empty=%b need 1", empty);
        end
        tick();
        checks++;
        if (empty !== 1'b0 || out_valid !== 1'b0 || r_inc !== 1'b1) begin
            errors++;
            $display("FAIL single_e3: empty=%b valid=%b inc=%b, need 0 0 1", empty, out_valid, r_inc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || empty !== 1'b1 || b_rptr !== 4'd1) begin
            errors++;
            $display("FAIL single_e4: valid=%b data=%h empty=%b b=%h, need 1 a5 1 1",
                     out_valid, out_data, empty, b_rptr);
        end
        checks++;
        if (r_inc !== 1'b0) begin
            errors++;
            $display("FAIL single_noinc: inc=%b need 0", r_inc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || b_rptr !== 4'd1) begin
            errors++;
            $display("FAIL single_e5: valid=%b b=%h, need 0 1", out_valid, b_rptr);
        end
    endtask

    task automatic test_drain_wrap();
        int got;
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
        out_ready = 1'b1;
        g_wptr = 4'b1100;
        tick();
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(k)) begin
                errors++;
                $display("FAIL drain_word%0d: valid=%b data=%h, need 1 %h",
                         k, out_valid, out_data, 8'h10 + 8'(k));
            end
        end
        checks++;
        if (b_rptr !== 4'd8 || g_rptr !== 4'b1100 || empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_ptr: b=%h g=%b empty=%b, need 8 1100 1", b_rptr, g_rptr, empty);
        end
        for (int i = 0; i < 8; i++) mem[i] = 8'h20 + 8'(i);
        g_wptr = 4'b0000;
        got = 0;
        for (int c = 0; c < 20 && got < 8; c++) begin
            tick();
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== 8'h20 + 8'(got)) begin
                    errors++;
                    $display("FAIL wrap_word%0d: data=%h need %h", got, out_data, 8'h20 + 8'(got));
                end
                got++;
            end
        end
        tick();
        checks++;
        if (got !== 8 || b_rptr !== 4'd0 || g_rptr !== 4'd0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: words=%0d b=%h g=%h empty=%b valid=%b, need 8 0 0 1 0",
                     got, b_rptr, g_rptr, empty, out_valid);
        end
    endtask

    task automatic test_backpressure();
        int pulses;
        do_reset();
        mem[0] = 8'h30;
        mem[1] = 8'h31;
        mem[2] = 8'h32;
        out_ready = 1'b0;
        g_wptr = 4'b0010;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (r_inc) pulses++;
            if (c >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h30 || b_rptr !== 4'd1) begin
                    errors++;
                    $display("FAIL bp_hold%0d: valid=%b data=%h b=%h, need 1 30 1",
                             c, out_valid, out_data, b_rptr);
                end
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL bp_pulses: got %0d need 1", pulses);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h31) begin
            errors++;
            $display("FAIL bp_w1: valid=%b data=%h, need 1 31", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h32 || empty !== 1'b1 || b_rptr !== 4'd3) begin
            errors++;
            $display("FAIL bp_w2: valid=%b data=%h empty=%b b=%h, need 1 32 1 3",
                     out_valid, out_data, empty, b_rptr);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid=%b need 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) mem[i] = 8'h40 + 8'(i);
        out_ready = 1'b1;
        g_wptr = 4'b0111;
        tick();
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h40 + 8'(k)) begin
                errors++;
                $display("FAIL mid_word%0d: valid=%b data=%h, need 1 %h",
                         k, out_valid, out_data, 8'h40 + 8'(k));
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || b_rptr !== 4'd0 || r_inc !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: valid=%b empty=%b b=%h inc=%b, need 0 1 0 0",
                     out_valid, empty, b_rptr, r_inc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || b_rptr !== 4'd0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: valid=%b empty=%b b=%h data=%h, need 0 1 0 00",
                     out_valid, empty, b_rptr, out_data);
        end
        g_wptr = 4'b0000;
        tick();
        rst_n = 1'b1;
    endtask

`ifdef RD_LEVEL_EN
    task automatic test_level();
        do_reset();
        out_ready = 1'b0;
        g_wptr = 4'b0111;
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (rd_level !== 4'd4 || almost_empty !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL level_4: level=%0d ae=%b valid=%b, need 4 0 1", rd_level, almost_empty, out_valid);
        end
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        checks++;
        if (rd_level !== 4'd1 || almost_empty !== 1'b1 || b_rptr !== 4'd4) begin
            errors++;
            $display("FAIL level_1: level=%0d ae=%b b=%h, need 1 1 4", rd_level, almost_empty, b_rptr);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        g_wptr = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        test_reset();
        test_single();
        test_drain_wrap();
        test_backpressure();
        test_reset_mid();
`ifdef RD_LEVEL_EN
        test_level();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
